// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART engine with runtime frame format
// (5..DATA_W data bits, none/even/odd parity, 1/1.5/2 stop bits).
// Bit timers are down-counters that reload per bit and act on terminal count.
//
// state        | meaning
// TX_IDLE      | line high, tx_ready_o=1, waiting for a handshake
// TX_START     | driving the start bit (0)
// TX_DATA      | shifting data bits out LSB first
// TX_PARITY    | driving the parity bit
// TX_STOP      | driving stop level for 1, 1.5 or 2 bit times
// RX_IDLE      | waiting for a low synchronised level
// RX_START     | qualifying the start bit by 3-sample majority
// RX_DATA      | capturing data bits LSB first
// RX_PARITY    | sampling and checking the parity bit
// RX_STOP      | first stop bit; the word completes at its vote
// RX_WAIT_HIGH | stop bit was low; hold until the line returns high
module uart_core_param #(
  parameter int DATA_W      = 8,
  parameter int CBP_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CBP_W-1:0]  cbp_i,
  input  logic [3:0]        data_len_i,
  input  logic [1:0]        parity_i,
  input  logic [1:0]        stop_bits_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_busy_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_parity_err_o,
  output logic              rx_frame_err_o,
  output logic              rx_overrun_o,
  input  logic              rx_i,
  output logic              tx_o
);
  localparam int CW = CBP_W + 1;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'd5) return 4'd5;
    else if (len > 4'(DATA_W)) return 4'(DATA_W);
    else return len;
  endfunction

  function automatic logic [DATA_W-1:0] len_mask(input logic [3:0] len);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) if (i < int'(len)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [CW-1:0] stop_len(input logic [CW-1:0] cbp, input logic [1:0] sel);
    case (sel)
      2'b00:   return cbp;
      2'b01:   return cbp + (cbp >> 1);
      default: return cbp << 1;
    endcase
  endfunction

  logic [CW-1:0] cbp_eff;
  logic [3:0]    len_c;
  logic [DATA_W-1:0] tx_masked;
  assign cbp_eff   = (cbp_i < CBP_W'(4)) ? CW'(4) : {1'b0, cbp_i};
  assign len_c     = clamp_len(data_len_i);
  assign tx_masked = tx_data_i & len_mask(len_c);

  // ---------------- TX ----------------
  tx_state_t tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, tx_cbp, tx_cbp_n;
  logic [3:0] tx_idx, tx_idx_n, tx_len, tx_len_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic [1:0] tx_par, tx_par_n, tx_stop, tx_stop_n;
  logic tx_pbit, tx_pbit_n, tx_n, tx_ready_n, tx_busy_n;

  // TX next-state and registered-output values
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_cbp_n   = tx_cbp;
    tx_idx_n   = tx_idx;
    tx_len_n   = tx_len;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_stop_n  = tx_stop;
    tx_pbit_n  = tx_pbit;
    tx_n       = tx_o;
    tx_ready_n = tx_ready_o;
    tx_busy_n  = tx_busy_o;
    if (tx_state != TX_IDLE && tx_cnt != '0) tx_cnt_n = tx_cnt - CW'(1);
    case (tx_state)
      TX_IDLE: if (tx_valid_i && tx_ready_o) begin
        tx_shift_n = tx_masked;
        tx_len_n   = len_c;
        tx_par_n   = parity_i;
        tx_stop_n  = stop_bits_i;
        tx_cbp_n   = cbp_eff;
        tx_pbit_n  = (^tx_masked) ^ (parity_i == 2'b10);
        tx_cnt_n   = cbp_eff - CW'(1);
        tx_state_n = TX_START;
        tx_n       = 1'b0;
        tx_ready_n = 1'b0;
        tx_busy_n  = 1'b1;
      end
      TX_START: if (tx_cnt == '0) begin
        tx_state_n = TX_DATA;
        tx_idx_n   = '0;
        tx_n       = tx_shift[0];
        tx_shift_n = tx_shift >> 1;
        tx_cnt_n   = tx_cbp - CW'(1);
      end
      TX_DATA: if (tx_cnt == '0) begin
        if (tx_idx == tx_len - 4'd1) begin
          if (tx_par == 2'b01 || tx_par == 2'b10) begin
            tx_state_n = TX_PARITY;
            tx_n       = tx_pbit;
            tx_cnt_n   = tx_cbp - CW'(1);
          end else begin
            tx_state_n = TX_STOP;
            tx_n       = 1'b1;
            tx_cnt_n   = stop_len(tx_cbp, tx_stop) - CW'(1);
          end
        end else begin
          tx_idx_n   = tx_idx + 4'd1;
          tx_n       = tx_shift[0];
          tx_shift_n = tx_shift >> 1;
          tx_cnt_n   = tx_cbp - CW'(1);
        end
      end
      TX_PARITY: if (tx_cnt == '0) begin
        tx_state_n = TX_STOP;
        tx_n       = 1'b1;
        tx_cnt_n   = stop_len(tx_cbp, tx_stop) - CW'(1);
      end
      TX_STOP: if (tx_cnt == '0) begin
        tx_state_n = TX_IDLE;
        tx_n       = 1'b1;
        tx_ready_n = 1'b1;
        tx_busy_n  = 1'b0;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE; tx_cnt <= '0; tx_cbp <= '0; tx_idx <= '0; tx_len <= '0;
      tx_shift <= '0; tx_par <= '0; tx_stop <= '0; tx_pbit <= 1'b0;
      tx_o <= 1'b1; tx_ready_o <= 1'b1; tx_busy_o <= 1'b0;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_cbp <= tx_cbp_n; tx_idx <= tx_idx_n;
      tx_len <= tx_len_n; tx_shift <= tx_shift_n; tx_par <= tx_par_n; tx_stop <= tx_stop_n;
      tx_pbit <= tx_pbit_n; tx_o <= tx_n; tx_ready_o <= tx_ready_n; tx_busy_o <= tx_busy_n;
    end
  end

  // ---------------- RX ----------------
  logic [SYNC_STAGES-1:0] sync;
  logic s;
  assign s = sync[SYNC_STAGES-1];

  // rx_i synchroniser, idles high
  always_ff @(posedge clk_i) begin
    if (rst_i) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], rx_i};
  end

  rx_state_t rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n, rx_cbp, rx_cbp_n, pt_a, pt_b, pt_c;
  logic [3:0] rx_idx, rx_idx_n, rx_len, rx_len_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n, rx_data_n;
  logic [1:0] rx_par, rx_par_n;
  logic smp0, smp0_n, smp1, smp1_n, pacc, pacc_n, perr, perr_n, maj, at_c, complete;
  logic rx_valid_n, rx_perr_n, rx_ferr_n, rx_ovr_n;

  // Down-counter values for the samples at counts h-1, h, h+1 of a bit
  assign pt_a = rx_cbp - (rx_cbp >> 1);
  assign pt_b = pt_a - CW'(1);
  assign pt_c = pt_a - CW'(2);
  assign at_c = (rx_cnt == pt_c);
  assign maj  = (smp0 & smp1) | (smp0 & s) | (smp1 & s);

  // RX next-state, capture and presented-word update
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_cbp_n   = rx_cbp;
    rx_idx_n   = rx_idx;
    rx_len_n   = rx_len;
    rx_shift_n = rx_shift;
    rx_par_n   = rx_par;
    smp0_n     = (rx_cnt == pt_a) ? s : smp0;
    smp1_n     = (rx_cnt == pt_b) ? s : smp1;
    pacc_n     = pacc;
    perr_n     = perr;
    complete   = 1'b0;
    if (rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH && rx_cnt != '0)
      rx_cnt_n = rx_cnt - CW'(1);
    case (rx_state)
      RX_IDLE: if (!s) begin
        rx_state_n = RX_START;
        rx_cbp_n   = cbp_eff;
        rx_cnt_n   = cbp_eff - CW'(1);
        rx_len_n   = len_c;
        rx_par_n   = parity_i;
        rx_idx_n   = '0;
        rx_shift_n = '0;
        pacc_n     = 1'b0;
        perr_n     = 1'b0;
      end
      RX_START: begin
        if (at_c && maj) rx_state_n = RX_IDLE;
        else if (rx_cnt == '0) begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = rx_cbp - CW'(1);
        end
      end
      RX_DATA: begin
        if (at_c) begin
          rx_shift_n = rx_shift | ({{(DATA_W-1){1'b0}}, maj} << rx_idx);
          pacc_n     = pacc ^ maj;
        end
        if (rx_cnt == '0) begin
          rx_cnt_n = rx_cbp - CW'(1);
          if (rx_idx == rx_len - 4'd1)
            rx_state_n = (rx_par == 2'b01 || rx_par == 2'b10) ? RX_PARITY : RX_STOP;
          else
            rx_idx_n = rx_idx + 4'd1;
        end
      end
      RX_PARITY: begin
        if (at_c) perr_n = maj ^ pacc ^ (rx_par == 2'b10);
        if (rx_cnt == '0) begin
          rx_state_n = RX_STOP;
          rx_cnt_n   = rx_cbp - CW'(1);
        end
      end
      RX_STOP: if (at_c) begin
        complete   = 1'b1;
        rx_state_n = maj ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (s) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase

    rx_data_n  = rx_data_o;
    rx_valid_n = rx_valid_o;
    rx_perr_n  = rx_parity_err_o;
    rx_ferr_n  = rx_frame_err_o;
    rx_ovr_n   = rx_overrun_o;
    if (rx_valid_o && rx_ready_i) begin
      rx_valid_n = 1'b0;
      rx_perr_n  = 1'b0;
      rx_ferr_n  = 1'b0;
      rx_ovr_n   = 1'b0;
    end
    if (complete) begin
      rx_data_n  = rx_shift;
      rx_perr_n  = perr;
      rx_ferr_n  = ~maj;
      rx_ovr_n   = rx_valid_o & ~rx_ready_i;
      rx_valid_n = 1'b1;
    end
  end

  // RX state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE; rx_cnt <= '0; rx_cbp <= '0; rx_idx <= '0; rx_len <= '0;
      rx_shift <= '0; rx_par <= '0; smp0 <= 1'b1; smp1 <= 1'b1; pacc <= 1'b0; perr <= 1'b0;
      rx_data_o <= '0; rx_valid_o <= 1'b0; rx_parity_err_o <= 1'b0;
      rx_frame_err_o <= 1'b0; rx_overrun_o <= 1'b0;
    end else begin
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_cbp <= rx_cbp_n; rx_idx <= rx_idx_n;
      rx_len <= rx_len_n; rx_shift <= rx_shift_n; rx_par <= rx_par_n; smp0 <= smp0_n;
      smp1 <= smp1_n; pacc <= pacc_n; perr <= perr_n;
      rx_data_o <= rx_data_n; rx_valid_o <= rx_valid_n; rx_parity_err_o <= rx_perr_n;
      rx_frame_err_o <= rx_ferr_n; rx_overrun_o <= rx_ovr_n;
    end
  end
endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: TX waveforms, loopback RX, injected
// RX errors, glitch rejection, overrun, break handling and mid-frame reset.
module tb_uart_core_param;
  localparam int DATA_W = 8;
  localparam int CBP_W  = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [CBP_W-1:0] cbp_i = 16'd16;
  logic [3:0] data_len_i = 4'd8;
  logic [1:0] parity_i = 2'b00;
  logic [1:0] stop_bits_i = 2'b00;
  logic [DATA_W-1:0] tx_data_i = '0;
  logic tx_valid_i = 1'b0;
  logic tx_ready_o, tx_busy_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_overrun_o, tx_o;
  logic [DATA_W-1:0] rx_data_o;
  logic rx_ready_i = 1'b0;
  logic rx_i;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;

  int checks = 0;
  int errors = 0;

  assign rx_i = loop_en ? tx_o : rx_drv;

  always #5 clk_i = ~clk_i;

  uart_core_param #(.DATA_W(DATA_W), .CBP_W(CBP_W), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cbp_i(cbp_i), .data_len_i(data_len_i),
    .parity_i(parity_i), .stop_bits_i(stop_bits_i), .tx_data_i(tx_data_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_busy_o(tx_busy_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_parity_err_o(rx_parity_err_o), .rx_frame_err_o(rx_frame_err_o),
    .rx_overrun_o(rx_overrun_o), .rx_i(rx_i), .tx_o(tx_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first START cycle; cbp is 16.
  task automatic check_frame(input string tag, input logic [8:0] d, input int len,
                             input int pbit, input int stop_cyc);
    int nslots;
    int total;
    int slot;
    logic e;
    nslots = 1 + len + ((pbit >= 0) ? 1 : 0);
    total  = nslots * 16 + stop_cyc;
    chk({tag, "_busy"}, {31'd0, tx_busy_o}, 32'd1);
    for (int k = 1; k <= total; k++) begin
      slot = (k - 1) / 16;
      if (slot == 0) e = 1'b0;
      else if (slot <= len) e = d[slot-1];
      else if (slot == len + 1 && pbit >= 0) e = pbit[0];
      else e = 1'b1;
      chk($sformatf("%s_bit@%0d", tag, k), {31'd0, tx_o}, {31'd0, e});
      @(negedge clk_i);
    end
    chk({tag, "_ready"}, {31'd0, tx_ready_o}, 32'd1);
    chk({tag, "_idle"}, {31'd0, tx_busy_o}, 32'd0);
  endtask

  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready_o && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    chk("tx_ready_wait", {31'd0, tx_ready_o}, 32'd1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  // Drives 16-cycle slots LSB first; optional one-cycle glitch and a
  // one-cycle rx_ready_i pulse at cycle rdy_at of the frame.
  task automatic drive_frame(input logic [15:0] bits, input int n, input int gslot,
                             input int goff, input int rdy_at);
    for (int c = 0; c < n * 16; c++) begin
      rx_drv     = bits[c/16] ^ ((c / 16 == gslot && c % 16 == goff) ? 1'b1 : 1'b0);
      rx_ready_i = (c == rdy_at);
      @(negedge clk_i);
    end
    rx_drv     = 1'b1;
    rx_ready_i = 1'b0;
    repeat (20) @(negedge clk_i);
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input logic ov);
    chk({tag, "_valid"}, {31'd0, rx_valid_o}, 32'd1);
    chk({tag, "_data"}, {24'd0, rx_data_o}, {24'd0, d});
    chk({tag, "_perr"}, {31'd0, rx_parity_err_o}, {31'd0, pe});
    chk({tag, "_ferr"}, {31'd0, rx_frame_err_o}, {31'd0, fe});
    chk({tag, "_ovr"}, {31'd0, rx_overrun_o}, {31'd0, ov});
  endtask

  task automatic consume(input string tag);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    chk({tag, "_consumed"}, {31'd0, rx_valid_o}, 32'd0);
    chk({tag, "_flags_clr"}, {29'd0, rx_parity_err_o, rx_frame_err_o, rx_overrun_o}, 32'd0);
  endtask

  function automatic logic [15:0] fr8n1(input logic [7:0] d, input logic stopb);
    return {6'd0, stopb, d, 1'b0};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_tx_o", {31'd0, tx_o}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy_o}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    chk("rst_flags", {29'd0, rx_parity_err_o, rx_frame_err_o, rx_overrun_o}, 32'd0);

    // 8N1 0xA5, tx_valid held with new data: latched data sent, then 0x3C back-to-back
    @(negedge clk_i);
    tx_data_i  = 8'hA5;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_data_i  = 8'h3C;
    check_frame("a5", 9'h0A5, 8, -1, 16);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    check_frame("3c", 9'h03C, 8, -1, 16);

    // loopback 7E2, bit 7 of tx data must be dropped
    loop_en = 1'b1;
    data_len_i = 4'd7; parity_i = 2'b01; stop_bits_i = 2'b10;
    send_word(8'hC1);
    check_frame("tx7e2", 9'h0C1, 7, 0, 32);
    check_word("rx7e2", 8'h41, 1'b0, 1'b0, 1'b0);
    consume("rx7e2");

    // loopback 8O1.5 0xFF
    data_len_i = 4'd8; parity_i = 2'b10; stop_bits_i = 2'b01;
    send_word(8'hFF);
    check_frame("tx8o15", 9'h0FF, 8, 1, 24);
    check_word("rx8o15", 8'hFF, 1'b0, 1'b0, 1'b0);
    consume("rx8o15");
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (5) @(negedge clk_i);

    // 8E1 0x03 with parity bit forced to 1
    parity_i = 2'b01; stop_bits_i = 2'b00;
    drive_frame({5'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1, 0, -1);
    check_word("perr", 8'h03, 1'b1, 1'b0, 1'b0);
    consume("perr");

    // 8N1 0x55 with stop bit 0
    parity_i = 2'b00;
    drive_frame(fr8n1(8'h55, 1'b0), 10, -1, 0, -1);
    check_word("ferr", 8'h55, 1'b0, 1'b1, 1'b0);
    consume("ferr");

    // 3-cycle low pulse is a false start
    rx_drv = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("false_start", {31'd0, rx_valid_o}, 32'd0);

    // glitch on data bit 3 centre sample of 0x5A
    drive_frame(fr8n1(8'h5A, 1'b1), 10, 4, 9, -1);
    check_word("glitch", 8'h5A, 1'b0, 1'b0, 1'b0);
    consume("glitch");

    // overrun: two words, no consume
    drive_frame(fr8n1(8'h11, 1'b1), 10, -1, 0, -1);
    check_word("ovr1", 8'h11, 1'b0, 1'b0, 1'b0);
    drive_frame(fr8n1(8'h22, 1'b1), 10, -1, 0, -1);
    check_word("ovr2", 8'h22, 1'b0, 1'b0, 1'b1);
    consume("ovr2");

    // consume in the completion cycle of the second word: no overrun
    drive_frame(fr8n1(8'h33, 1'b1), 10, -1, 0, -1);
    check_word("cc1", 8'h33, 1'b0, 1'b0, 1'b0);
    drive_frame(fr8n1(8'h44, 1'b1), 10, -1, 0, 156);
    check_word("cc2", 8'h44, 1'b0, 1'b0, 1'b0);
    consume("cc2");

    // line held low 400 cycles: exactly one word
    rx_drv = 1'b0;
    repeat (400) @(negedge clk_i);
    check_word("brk", 8'h00, 1'b0, 1'b1, 1'b0);
    rx_drv = 1'b1;
    repeat (10) @(negedge clk_i);
    consume("brk");
    drive_frame(fr8n1(8'h5A, 1'b1), 10, -1, 0, -1);
    check_word("after_brk", 8'h5A, 1'b0, 1'b0, 1'b0);
    consume("after_brk");

    // reset during TX DATA in loopback
    loop_en = 1'b1;
    send_word(8'h96);
    repeat (20) @(negedge clk_i);
    chk("pre_rst_tx_o", {31'd0, tx_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_rst_tx_o", {31'd0, tx_o}, 32'd1);
    chk("mid_rst_ready", {31'd0, tx_ready_o}, 32'd1);
    chk("mid_rst_busy", {31'd0, tx_busy_o}, 32'd0);
    repeat (300) @(negedge clk_i);
    chk("mid_rst_no_rx", {31'd0, rx_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART engine, successor to the fixed 8-bit core. Adds:
- runtime data length
- optional even/odd parity
- 1/1.5/2 stop bits
- RX input synchroniser and 3-sample majority voting
- per-frame parity, framing and overrun status
- valid/ready handshakes on both directions

Sits between the bus-side UART register block and the pins.

Parameters:
DATA_W, 8, maximum data bits per frame (5..9); width of tx_data_i/rx_data_o
CBP_W, 16, width of clocks-per-bit divisor
SYNC_STAGES, 2, flops in rx_i synchroniser (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cbp_i  in  CBP_W  clocks per bit; values <4 treated as 4
data_len_i  in  4  data bits per frame; <5 -> 5, >DATA_W -> DATA_W
parity_i  in  2  00/11 none, 01 even, 10 odd
stop_bits_i  in  2  00 one, 01 one-and-half, 10/11 two
tx_data_i  in  DATA_W  byte to send, LSB first
tx_valid_i  in  1  TX request
tx_ready_o  out  1  TX engine idle, accepts request
tx_busy_o  out  1  frame in progress
rx_data_o  out  DATA_W  received data, zero-extended above data_len
rx_valid_o  out  1  rx_data_o/status valid
rx_ready_i  in  1  consumer accepts RX word
rx_parity_err_o  out  1  parity mismatch on presented word
rx_frame_err_o  out  1  first stop bit sampled 0
rx_overrun_o  out  1  presented word overwrote an unconsumed one
rx_i  in  1  serial input (asynchronous)
tx_o  out  1  serial output (registered)

Behaviour:
- Reset: all outputs registered.
  - tx_o=1, tx_ready_o=1, tx_busy_o=0.
  - rx_valid_o=0, rx_data_o=0, all error flags 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame aborts both engines. tx_o=1 the next cycle. Partial RX data is discarded.
- TX states: IDLE, START, DATA, PARITY, STOP.
  - Handshake when tx_valid_i && tx_ready_o. Data, data_len, parity and stop config are latched at this point; later input changes do not affect the frame in flight.
  - The cycle after the handshake: tx_ready_o=0, tx_busy_o=1, tx_o=0 (START).
  - Each bit lasts cbp cycles: START, then data_len DATA bits LSB first, then PARITY if enabled, then STOP.
  - Parity bit: even = XOR of the sent data bits; odd = its inverse.
  - STOP lasts cbp, cbp+(cbp>>1), or 2*cbp cycles.
  - On the cycle after the last STOP cycle: tx_ready_o=1, tx_busy_o=0. A new handshake in that cycle starts the next START on the following cycle, so frames run back-to-back with no idle gap.
- RX states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Synchronised rx level s, latency SYNC_STAGES.
  - IDLE -> START when s=0. The bit counter is reset on that cycle.
  - Let h=cbp>>1. Each bit is sampled at counts h-1, h and h+1 within the bit; majority of the three decides the bit value.
  - START majority 1 -> false start: return to IDLE with no flags.
  - DATA captures data_len bits LSB first, then PARITY if enabled.
  - Only the first stop bit is checked. At its h+1 sample the word completes:
    - rx_data_o, rx_parity_err_o and rx_frame_err_o load together; rx_valid_o=1 on the next cycle.
    - Receiver returns to IDLE if the stop bit was 1.
    - Receiver goes to WAIT_HIGH if the stop bit was 0 (break/framing). It stays there until s=1, so a held-low line yields exactly one word.
  - rx_valid_o holds until rx_valid_o && rx_ready_i, which clears valid and all three flags.
  - New word completes while valid and not consumed that cycle: data and flags are overwritten, rx_overrun_o=1, valid stays 1.
  - Completion and consume in the same cycle: the new word loads, valid stays 1, overrun=0.
- TX and RX are fully independent. Config changes mid-RX-frame take effect from the next START.
- Counters are CBP_W+1 bits, so 2*cbp never wraps.

Test Plan:
- cbp=16, 8N1, send 0xA5 at cycle 0:
  - tx_o=0 over cycles 1-16.
  - Bits 1,0,1,0,0,1,0,1 in 16-cycle slots.
  - Stop over cycles 145-160.
  - tx_ready_o=1 at cycle 161.
  - Two back-to-back words: second START at cycle 161.
- Loopback tx_o->rx_i, cbp=16, 7E2, send 0x41:
  - Parity bit 0, frame length 176 cycles.
  - rx_data_o=0x41, rx_valid_o=1, no error flags.
  - 8O1.5 with 0xFF: parity bit 1, stop 24 cycles.
- Inject a parity bit of 1 into 8E1 0x03 -> rx_parity_err_o=1 with rx_data_o=0x03.
  - Inject stop=0 -> rx_frame_err_o=1.
- rx_i low for 3 cycles only, cbp=16 -> no rx_valid_o.
  - One-cycle glitch at a data bit's centre sample -> majority keeps the correct value.
- Two frames received, rx_ready_i=0 -> second word presented with rx_overrun_o=1.
  - rx_ready_i asserted in the completion cycle of the second frame -> rx_overrun_o=0.
- rx_i held 0 for 400 cycles at 8N1 cbp=16 -> exactly one word 0x00 with frame_err=1.
  - Then rx_i=1 and a valid 0x5A frame is received.
  - rst_i during TX DATA -> tx_o=1 next cycle, tx_ready_o=1, and no RX word from the aborted frame.
